data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised byte-lane data memory for the MEM stage. Replaces the fixed 32-bit, 4-RAM data memory.
//  Adds a valid/ready request port, sub-word lane steering, zero/sign extension, LDM/STM/PUSH/POP burst sequencing
//  and a registered response with last-beat and fault flags.
// PARAMETERS
//  DATA_W      32    data width in bits; multiple of 8; LANES = DATA_W/8 byte lanes
//  DEPTH_WORDS 1024  words per lane RAM; power of 2
//  ADDR_W      32    byte-address width
//  MAX_BURST   16    maximum beats in one burst (LDM/STM/PUSH/POP register count)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  req_valid  in   1                   request beat valid
//  req_ready  out  1                   block accepts beat this cycle
//  req_we     in   1                   1 = store, 0 = load
//  req_size   in   2                   dmem_pkg::size_e: 0 byte, 1 half, 3 word (2 reserved = word)
//  req_signed in   1                   sign-extend load result
//  req_addr   in   ADDR_W              byte address; used on the first beat only
//  req_count  in   $clog2(MAX_BURST)+1 beats in burst, sampled on the first beat; 0 treated as 1
//  req_wdata  in   DATA_W              store data, right-aligned
//  rsp_valid  out  1                   response for the beat accepted last cycle
//  rsp_rdata  out  DATA_W              load data (0 for stores)
//  rsp_last   out  1                   response is the final beat of its burst
//  rsp_fault  out  1                   misaligned access (DMEM_ALIGN_CHECK_EN only, else 0)
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready (1 once rst_n=1); FSM=IDLE; beat counter 0. RAM contents not reset.
//  Handshake: a beat transfers when req_valid && req_ready. req_ready=1 in IDLE and BURST. One beat per cycle.
//   rsp_valid is asserted exactly 1 cycle after each accepted beat. There is no response back-pressure.
//  FSM IDLE: beat accepted with count<=1 -> single access, stay IDLE.
//   Beat accepted with count>1 -> latch base addr, size forced to word, remaining=count-1, go to BURST.
//  FSM BURST: each accepted beat uses internal addr (prev+LANES). req_addr/req_size/req_count are ignored.
//   req_we must equal the first beat's value; a mismatched beat is still executed with the latched we.
//   After the beat where remaining==1 -> IDLE. Without a beat, state and remaining hold.
//  Word index = addr[$clog2(LANES)+:$clog2(DEPTH_WORDS)]. Upper bits ignored (aliasing); burst addr wraps mod depth.
//  Offset off = addr[$clog2(LANES)-1:0]. Store: lane i written iff off <= i < off+bytes(size).
//   Write data is rotated left by off bytes.
//  Load: lane read data is rotated right by off bytes, masked to bytes(size), then zero- or sign-extended
//   from bit 8*bytes-1 per the registered req_signed. Store responses: rdata=0.
//  RAM read is synchronous (1 cycle); size/signed/off/last are registered alongside, aligned to rsp_valid.
//  rsp_last=1 for single accesses and for the final burst beat.
//  Reset mid-burst: burst abandoned, completed stores remain in RAM, no response for the in-flight beat.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: half with off[0]!=0 or word with off!=0 is misaligned.
//   No lanes written; response has rsp_fault=1, rdata=0, rsp_last=1. A burst in progress is aborted -> IDLE.
//  Not defined: off bits below the access size are forced to 0 (access aligned down); rsp_fault tied 0.
// STRUCTURE
//  dmem_pkg: size_e enum (SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd3); state_e {IDLE, BURST};
//   function bytes_of(size_e); typedef rsp_meta_t {size, signed, off, last, fault, we}.
//  Sub-module dmem_lane_ram: 8-bit x DEPTH_WORDS single-port, sync read, write enable.
//   Generated LANES times. Burst FSM, lane steering and response regs stay in data_mem_ctrl.
// TESTING
//  1. SW 0xDEADBEEF @0x100, then LW @0x100 -> rsp 1 cycle later rdata=0xDEADBEEF, last=1.
//  2. SB 0x80 @0x103, LDRSB @0x103 -> 0xFFFFFF80; LDRB -> 0x00000080; LW @0x100 -> 0x80ADBEEF.
//  3. STM count=4 base 0x200 data 1,2,3,4 (req_addr garbage after beat 1), then LDM count=4 @0x200
//     -> rdata 1,2,3,4 on consecutive cycles, rsp_last only on 4th.
//  4. Burst at last word (0xFFC, DEPTH_WORDS=1024) count=2 -> second beat hits word 0 (wrap).
//  5. LDRH @0x101: with DMEM_ALIGN_CHECK_EN -> rsp_fault=1, rdata=0, RAM unchanged; without it -> data from 0x100.
//  6. rst_n low during beat 2 of a 4-beat STM -> outputs 0 next edge, FSM IDLE, beat 1 data retained.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the byte-lane data memory.
// Access sizes, burst FSM states and response metadata.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int OFF_MAX_W = 8;

    typedef struct packed {
        size_e                size;
        logic                 sgn;
        logic [OFF_MAX_W-1:0] off;
        logic                 last;
        logic                 fault;
        logic                 we;
    } rsp_meta_t;

    function automatic int bytes_of(size_e s, int lanes);
        int n;
        case (s)
            SZ_BYTE: n = 1;
            SZ_HALF: n = 2;
            default: n = lanes;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One 8-bit byte lane of the data memory.
// Single port, synchronous read, write enable; contents not reset.
module dmem_lane_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    // Write when enabled; read returns the old contents one cycle later.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: lane steering, extension, burst FSM.
// Optional misalignment faults with DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_signed,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [$clog2(MAX_BURST):0]   req_count,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_last,
    output logic                         rsp_fault
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LOW_W = OFF_W + IDX_W;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_e             state_q, state_d;
    logic [LOW_W-1:0]   addr_q, addr_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               rsp_valid_q, rsp_valid_d;
    rsp_meta_t          meta_q, meta_d;

    logic               acc;
    size_e              sz_in, cur_sz;
    logic [CNT_W-1:0]   cnt_eff;
    logic [LOW_W-1:0]   cur_addr;
    logic               cur_we, cur_last, fault;
    logic [OFF_W-1:0]   raw_off, mask, off;
    logic [IDX_W-1:0]   idx;
    int                 nb, offi;
    logic [LANES-1:0]   lane_we;
    logic [DATA_W-1:0]  wrot, rd_word, rrot;

    assign req_ready = rst_n;
    assign acc       = req_valid && req_ready;

    // Pick the beat's address/size and steer store bytes into lanes.
    always_comb begin
        unique case (1'b1)
            (req_size == 2'd0): sz_in = SZ_BYTE;
            (req_size == 2'd1): sz_in = SZ_HALF;
            default:            sz_in = SZ_WORD;
        endcase
        cnt_eff = (req_count == '0) ? CNT_W'(1) : req_count;
        if (state_q == IDLE) begin
            cur_addr = req_addr[LOW_W-1:0];
            cur_we   = req_we;
            cur_sz   = (cnt_eff > CNT_W'(1)) ? SZ_WORD : sz_in;
            cur_last = (cnt_eff <= CNT_W'(1));
        end else begin
            cur_addr = addr_q;
            cur_we   = we_q;
            cur_sz   = SZ_WORD;
            cur_last = (rem_q == CNT_W'(1));
        end
        nb      = bytes_of(cur_sz, LANES);
        raw_off = cur_addr[OFF_W-1:0];
        mask    = OFF_W'(nb - 1);
`ifdef DMEM_ALIGN_CHECK_EN
        fault   = |(raw_off & mask);
        off     = raw_off;
`else
        fault   = 1'b0;
        off     = raw_off & ~mask;
`endif
        if (fault) begin
            cur_last = 1'b1;
        end
        idx  = cur_addr[OFF_W +: IDX_W];
        offi = int'(off);
        wrot = (req_wdata << (8 * offi))
             | (req_wdata >> (8 * (LANES - offi)));
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = acc && cur_we && !fault
                       && (i >= offi) && (i < offi + nb);
        end
    end

    // Burst sequencing and response metadata for the next cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        rem_d       = rem_q;
        rsp_valid_d = acc;
        meta_d      = meta_q;
        if (acc) begin
            meta_d.size  = cur_sz;
            meta_d.sgn   = req_signed;
            meta_d.off   = OFF_MAX_W'(off);
            meta_d.last  = cur_last;
            meta_d.fault = fault;
            meta_d.we    = cur_we;
        end
        unique case (state_q)
            IDLE: begin
                if (acc && !fault && cnt_eff > CNT_W'(1)) begin
                    state_d = BURST;
                    addr_d  = cur_addr + LOW_W'(LANES);
                    we_d    = req_we;
                    rem_d   = cnt_eff - CNT_W'(1);
                end
            end
            BURST: begin
                if (acc) begin
                    if (fault || rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d   = rem_q - CNT_W'(1);
                        addr_d  = addr_q + LOW_W'(LANES);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, burst and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b0;
            meta_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            rem_q       <= rem_d;
            rsp_valid_q <= rsp_valid_d;
            meta_q      <= meta_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmem_lane_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
            .clk   (clk),
            .we    (lane_we[i]),
            .addr  (idx),
            .wdata (wrot[8*i +: 8]),
            .rdata (rd_word[8*i +: 8])
        );
    end

    // Realign read lanes, mask to size and extend.
    always_comb begin
        int roff, rnb;
        logic sbit;
        roff = int'(meta_q.off[OFF_W-1:0]);
        rnb  = bytes_of(meta_q.size, LANES);
        rrot = (rd_word >> (8 * roff))
             | (rd_word << (8 * (LANES - roff)));
        sbit = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (j == rnb - 1) begin
                sbit = meta_q.sgn & rrot[8*j + 7];
            end
        end
        rsp_rdata = '0;
        for (int j = 0; j < LANES; j++) begin
            rsp_rdata[8*j +: 8] = (j < rnb) ? rrot[8*j +: 8] : {8{sbit}};
        end
        if (!rsp_valid_q || meta_q.we || meta_q.fault) begin
            rsp_rdata = '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_last  = rsp_valid_q & meta_q.last;
    assign rsp_fault = rsp_valid_q & meta_q.fault;

    logic unused_bits;
    assign unused_bits = &{1'b0, req_addr[ADDR_W-1:LOW_W],
                           meta_q.off[OFF_MAX_W-1:OFF_W]};

endmodule
